// File: rtl/gpio_debounce_if.sv
// gpio_debounce_if
//   Bundles the pad-side and status signals of gpio_debounce.
//   master : drives pin_i, thresh_i, clr_i; observes the conditioned outputs.
//   slave  : the debouncer itself.
//   Signals:
//     pin_i    [WIDTH]  raw asynchronous pad inputs
//     thresh_i [CNT_W]  debounce threshold in clock cycles (0 acts as 1)
//     clr_i    [WIDTH]  write-1-to-clear strobe for pend_o
//     gpio_o   [WIDTH]  debounced levels
//     rise_o   [WIDTH]  one-cycle pulse on debounced 0->1
//     fall_o   [WIDTH]  one-cycle pulse on debounced 1->0
//     pend_o   [WIDTH]  sticky edge-pending flags
//     irq_o             OR of pend_o
interface gpio_debounce_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] pin_i;
    logic [CNT_W-1:0] thresh_i;
    logic [WIDTH-1:0] clr_i;
    logic [WIDTH-1:0] gpio_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;
    logic [WIDTH-1:0] pend_o;
    logic             irq_o;

    modport master (
        output pin_i, thresh_i, clr_i,
        input  gpio_o, rise_o, fall_o, pend_o, irq_o
    );

    modport slave (
        input  pin_i, thresh_i, clr_i,
        output gpio_o, rise_o, fall_o, pend_o, irq_o
    );
endinterface

// File: rtl/gpio_debounce.sv
// gpio_debounce
//   Per-pin input conditioner: two-flop synchronizer, then a counter that
//   requires the synchronized level to disagree with the debounced level for
//   an effective-threshold number of consecutive cycles before accepting it.
//   Debounced edges produce one-cycle rise/fall pulses.
//
//   Optional feature, macro GPIO_DEBOUNCE_IRQ_EN:
//     defined   -> sticky pend_o flags (set by rise/fall, write-1-to-clear via
//                  clr_i, set wins) and irq_o = |pend_o.
//     undefined -> pend_o and irq_o tied to 0, clr_i ignored.
//
//   Ports:
//     clk_i  single clock, all state on rising edge
//     rst_i  asynchronous active-high reset
//     bus    gpio_debounce_if.slave (pin_i, thresh_i, clr_i in;
//            gpio_o, rise_o, fall_o, pend_o, irq_o out)
module gpio_debounce #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    gpio_debounce_if.slave bus
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] gpio_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] upd;
    logic [CNT_W-1:0] thresh_eff;

    assign thresh_eff = (bus.thresh_i == '0) ? CNT_W'(1) : bus.thresh_i;

    // Compare in CNT_W+1 bits so counter+1 cannot overflow the comparison.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            upd[i]   = 1'b0;
            if (sync2_q[i] != gpio_q[i]) begin
                if (({1'b0, cnt_q[i]} + (CNT_W+1)'(1)) >= {1'b0, thresh_eff}) begin
                    upd[i] = 1'b1;
                end else if (cnt_q[i] != '1) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end else begin
                    cnt_d[i] = cnt_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            gpio_q  <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= bus.pin_i;
            sync2_q <= sync1_q;
            gpio_q  <= gpio_q ^ upd;
            rise_q  <= upd & ~gpio_q;
            fall_q  <= upd & gpio_q;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.gpio_o = gpio_q;
    assign bus.rise_o = rise_q;
    assign bus.fall_o = fall_q;

`ifdef GPIO_DEBOUNCE_IRQ_EN
    logic [WIDTH-1:0] pend_q;

    // Flags are set from the registered edge pulses; a coincident clear loses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~bus.clr_i) | rise_q | fall_q;
        end
    end

    assign bus.pend_o = pend_q;
    assign bus.irq_o  = |pend_q;
`else
    logic unused_clr;

    assign unused_clr = ^bus.clr_i;
    assign bus.pend_o = '0;
    assign bus.irq_o  = 1'b0;
`endif

endmodule

// File: doc/gpio_debounce.md
GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of input pins conditioned.
REQ-002 SHALL have parameter CNT_W, default 16, width of the per-pin debounce counter and threshold.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port pin_i  input  WIDTH  raw asynchronous pad inputs.
REQ-006 SHALL have port thresh_i  input  CNT_W  debounce threshold in clk_i cycles, shared by all pins.
REQ-007 SHALL have port clr_i  input  WIDTH  per-pin pending-clear strobe, one cycle, write-1-to-clear.
REQ-008 SHALL have port gpio_o  output  WIDTH  debounced pin levels; drives gpio.gpio_i.
REQ-009 SHALL have port rise_o  output  WIDTH  one-cycle pulse per pin on debounced 0->1.
REQ-010 SHALL have port fall_o  output  WIDTH  one-cycle pulse per pin on debounced 1->0.
REQ-011 SHALL have port pend_o  output  WIDTH  sticky per-pin edge-pending flags.
REQ-012 SHALL have port irq_o  output  1  OR-reduction of pend_o.

Function
REQ-013 SHALL pass each pin_i bit through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-014 SHALL compute the effective threshold as thresh_i, with 0 treated as 1.
REQ-015 SHALL per pin, when sync2 equals gpio_o, load counter with 0.
REQ-016 SHALL per pin, when sync2 differs from gpio_o and counter+1 >= effective threshold, load gpio_o with sync2 and counter with 0.
REQ-017 SHALL per pin, when sync2 differs from gpio_o otherwise, increment counter; counter saturates at all-ones and never wraps.
REQ-018 SHALL give latency pin_i change -> gpio_o change of exactly 2 + effective-threshold rising edges when pin_i is held stable.
REQ-019 SHALL ignore any pin_i pulse shorter than the effective threshold (as seen at sync2); no gpio_o change and no edge pulse.
REQ-020 SHALL assert rise_o[i] or fall_o[i] in the same cycle gpio_o[i] takes its new value, for exactly one cycle.
REQ-021 SHALL apply a thresh_i change immediately: if counter+1 >= new effective threshold, the update occurs on that edge.
REQ-022 SHALL treat every pin independently; simultaneous transitions on several pins each resolve per REQ-015..REQ-017.
REQ-023 SHALL set pend_o[i] on rise_o[i] or fall_o[i], and clear it on clr_i[i]; when set and clear coincide, set wins.
REQ-024 SHALL drive irq_o combinationally from pend_o, with no added latency.

Reset
REQ-025 SHALL on rst_i asynchronously force sync1, sync2, gpio_o, all counters, rise_o, fall_o, pend_o and irq_o to 0.
REQ-026 SHALL abandon any in-progress debounce on reset; after release, a held-high pin reaches gpio_o after 2 + effective-threshold edges.

Configuration
REQ-027 SHALL, with GPIO_DEBOUNCE_IRQ_EN defined, implement pend_o and irq_o per REQ-023..REQ-024.
REQ-028 SHALL, without GPIO_DEBOUNCE_IRQ_EN, tie pend_o and irq_o to 0, ignore clr_i, and instantiate no pending flops; rise_o/fall_o remain.

Verification
REQ-029 SHALL cover: thresh_i=4, pin_i 0x00->0x01 held -> gpio_o=0x01 exactly 6 edges later, rise_o=0x01 for that one cycle.
REQ-030 SHALL cover: thresh_i=4, pin_i[1] high for 3 cycles then low -> gpio_o stays 0x00, rise_o/fall_o stay 0.
REQ-031 SHALL cover: thresh_i=0, pin_i=0xFF -> gpio_o=0xFF after 3 edges; pin_i=0x00 -> fall_o=0xFF for one cycle.
REQ-032 SHALL cover: IRQ_EN on, debounced edge on pin 2 -> pend_o=0x04, irq_o=1; clr_i=0x04 coincident with a new pin-2 edge -> pend_o stays 0x04; clr_i=0x04 alone -> pend_o=0x00, irq_o=0.
REQ-033 SHALL cover: thresh_i=8, pin_i[0] high, rst_i asserted 5 cycles in -> gpio_o, counters, pend_o 0 immediately; after release, gpio_o[0]=1 after 10 edges.
REQ-034 SHALL cover: IRQ_EN off, edges on all pins with clr_i toggling -> pend_o=0x00 and irq_o=0 throughout.
